// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin two-source transmit scheduler in front of rgmii_tx
module tx_arbiter #(
    parameter int IFG_CYCLES = 12,
    parameter int MAX_BYTES  = 1500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       s_req,
    input  logic [1:0][47:0] s_dest,
    input  logic [1:0][15:0] s_ethertype,
    input  logic [1:0]       s_ovalid,
    input  logic [1:0][7:0]  s_dout,
    output logic [1:0]       s_en,
    output logic [1:0]       s_done,
    output logic [1:0]       s_abort,
    output logic             tx_txen,
    output logic [7:0]       tx_txd,
    output logic [47:0]      tx_dest,
    output logic [15:0]      tx_ethertype,
    input  logic             tx_send_next,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    localparam logic [10:0] MAX_CNT  = 11'(MAX_BYTES);
    localparam logic [7:0]  GAP_LOAD = 8'(IFG_CYCLES - 1);

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [10:0] byte_cnt;
    logic [7:0]  gap_cnt;
    logic        pick;
    logic        cur_valid;
    logic        limit_hit;

    // On a tie the source that did not win last time goes first.
    always_comb begin
        pick      = (s_req == 2'b11) ? ~last_grant : s_req[1];
        cur_valid = s_ovalid[grant];
        limit_hit = cur_valid && (byte_cnt == MAX_CNT);
        s_en      = 2'b00;
        if (state == STREAM && !limit_hit) begin
            s_en[grant] = tx_send_next;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            byte_cnt     <= '0;
            gap_cnt      <= '0;
            tx_txen      <= 1'b0;
            tx_txd       <= '0;
            tx_dest      <= '0;
            tx_ethertype <= '0;
            s_done       <= 2'b00;
            s_abort      <= 2'b00;
        end else begin
            s_done  <= 2'b00;
            s_abort <= 2'b00;
            case (state)
                IDLE: begin
                    if (|s_req) begin
                        grant        <= pick;
                        last_grant   <= pick;
                        tx_dest      <= s_dest[pick];
                        tx_ethertype <= s_ethertype[pick];
                        tx_txen      <= 1'b1;
                        byte_cnt     <= '0;
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    // End of frame outranks the watchdog when both coincide.
                    if (!cur_valid) begin
                        tx_txen       <= 1'b0;
                        tx_txd        <= '0;
                        s_done[grant] <= 1'b1;
                        gap_cnt       <= GAP_LOAD;
                        state         <= GAP;
                    end else if (limit_hit) begin
                        tx_txen        <= 1'b0;
                        tx_txd         <= '0;
                        s_abort[grant] <= 1'b1;
                        gap_cnt        <= GAP_LOAD;
                        state          <= GAP;
                    end else if (tx_send_next) begin
                        tx_txd   <= s_dout[grant];
                        byte_cnt <= byte_cnt + 11'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - directed self-checking bench for tx_arbiter
module tb_tx_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       s_req, s_ovalid;
    logic [1:0][47:0] s_dest;
    logic [1:0][15:0] s_ethertype;
    logic [1:0][7:0]  s_dout;
    logic             tx_send_next;
    logic [1:0]       en_a, done_a, abort_a, en_b, done_b, abort_b;
    logic             txen_a, txen_b, busy_a, busy_b;
    logic [7:0]       txd_a, txd_b;
    logic [47:0]      dest_a, dest_b;
    logic [15:0]      et_a, et_b;

    tx_arbiter dut_a (
        .clk(clk), .rst(rst), .s_req(s_req), .s_dest(s_dest), .s_ethertype(s_ethertype),
        .s_ovalid(s_ovalid), .s_dout(s_dout), .s_en(en_a), .s_done(done_a), .s_abort(abort_a),
        .tx_txen(txen_a), .tx_txd(txd_a), .tx_dest(dest_a), .tx_ethertype(et_a),
        .tx_send_next(tx_send_next), .busy(busy_a)
    );

    tx_arbiter #(.IFG_CYCLES(12), .MAX_BYTES(8)) dut_b (
        .clk(clk), .rst(rst), .s_req(s_req), .s_dest(s_dest), .s_ethertype(s_ethertype),
        .s_ovalid(s_ovalid), .s_dout(s_dout), .s_en(en_b), .s_done(done_b), .s_abort(abort_b),
        .tx_txen(txen_b), .tx_txd(txd_b), .tx_dest(dest_b), .tx_ethertype(et_b),
        .tx_send_next(tx_send_next), .busy(busy_b)
    );

    logic       sel;
    logic [1:0] en_s, done_s, abort_s;
    logic       txen_s, busy_s;
    logic [7:0] txd_s;
    logic [15:0] et_s;
    assign en_s    = sel ? en_b    : en_a;
    assign done_s  = sel ? done_b  : done_a;
    assign abort_s = sel ? abort_b : abort_a;
    assign txen_s  = sel ? txen_b  : txen_a;
    assign busy_s  = sel ? busy_b  : busy_a;
    assign txd_s   = sel ? txd_b   : txd_a;
    assign et_s    = sel ? et_b    : et_a;

    int n_tests = 0;
    int n_fail  = 0;
    int len[2], base[2], nfr[2], start[2], idx[2], nbytes[2], ndone[2], nabort[2];
    int cyc_n, pull_per, lowrun;
    bit txen_prev, had_frame, en1_seen, en_in_gap;
    logic [7:0] cap[$];
    int grants[$];
    int gaps[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 2; i++) begin
            s_req[i]    = (nfr[i] > 0) && (cyc_n >= start[i]);
            s_ovalid[i] = idx[i] < len[i];
            s_dout[i]   = 8'(base[i] + idx[i]);
        end
        tx_send_next = (cyc_n % pull_per) == 0;
    endtask

    // Source model: consumes a byte whenever its pull and valid coincide before an edge.
    task automatic cyc();
        logic [1:0] hs;
        @(negedge clk);
        hs = en_s & s_ovalid;
        if (en_s[1]) en1_seen = 1'b1;
        if ((|en_s) && busy_s && !txen_s) en_in_gap = 1'b1;
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                idx[i]++;
                nbytes[i]++;
            end
        end
        if (|hs) cap.push_back(txd_s);
        for (int i = 0; i < 2; i++) begin
            if (done_s[i] || abort_s[i]) begin
                if (done_s[i]) ndone[i]++;
                if (abort_s[i]) nabort[i]++;
                if (nfr[i] > 0) nfr[i]--;
                idx[i] = 0;
            end
        end
        if (txen_s && !txen_prev) begin
            grants.push_back((et_s == 16'h0806) ? 0 : 1);
            if (had_frame) gaps.push_back(lowrun);
            had_frame = 1'b1;
        end
        lowrun    = txen_s ? 0 : lowrun + 1;
        txen_prev = txen_s;
        drive_src();
    endtask

    task automatic do_reset(input logic which);
        rst = 1'b0;
        sel = which;
        for (int i = 0; i < 2; i++) begin
            nfr[i] = 0; idx[i] = 0; nbytes[i] = 0; ndone[i] = 0; nabort[i] = 0;
            start[i] = 0; len[i] = 0; base[i] = 0;
        end
        cyc_n = 0; pull_per = 1; lowrun = 0;
        txen_prev = 1'b0; had_frame = 1'b0; en1_seen = 1'b0; en_in_gap = 1'b0;
        cap.delete(); grants.delete(); gaps.delete();
        drive_src();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_frames(input string tag, input int budget);
        int n = 0;
        drive_src();
        while ((nfr[0] > 0 || nfr[1] > 0 || busy_s) && n < budget) begin
            cyc();
            n++;
        end
        check({tag, "_in_time"}, 64'(n < budget), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        s_dest[0] = 48'h02AA_BBCC_DD00;
        s_dest[1] = 48'h0611_2233_4455;
        s_ethertype[0] = 16'h0806;
        s_ethertype[1] = 16'h0800;

        // Reset state with every input pushing for activity.
        rst = 1'b0; sel = 1'b0;
        s_req = 2'b11; s_ovalid = 2'b11; s_dout = '1; tx_send_next = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ctl", {txen_a, txd_a, en_a, done_a, abort_a, busy_a}, 64'd0);
        check("rst_a_hdr", {dest_a, et_a}, 64'd0);
        check("rst_b_ctl", {txen_b, txd_b, en_b, done_b, abort_b, busy_b}, 64'd0);

        // Single ARP frame, pull every 2nd cycle.
        do_reset(1'b0);
        len[0] = 28; base[0] = 1; nfr[0] = 1; pull_per = 2;
        run_frames("arp", 400);
        check("arp_nbytes", 64'(cap.size()), 64'd28);
        for (int i = 0; i < 28; i++)
            check("arp_byte", (i < cap.size()) ? 64'(cap[i]) : 64'hFFFF, 64'(i + 1));
        check("arp_dest", 64'(dest_a), 64'h02AA_BBCC_DD00);
        check("arp_ethertype", 64'(et_a), 64'h0806);
        check("arp_done", 64'(ndone[0]), 64'd1);
        check("arp_abort", 64'(nabort[0]), 64'd0);
        check("arp_en1_quiet", 64'(en1_seen), 64'd0);

        // Simultaneous requests from reset: 0,1,0 with 13-cycle gaps.
        do_reset(1'b0);
        len[0] = 4; base[0] = 8'h10; nfr[0] = 2;
        len[1] = 4; base[1] = 8'h20; nfr[1] = 1;
        run_frames("rr", 400);
        check("rr_ngrants", 64'(grants.size()), 64'd3);
        if (grants.size() == 3) begin
            check("rr_grant0", 64'(grants[0]), 64'd0);
            check("rr_grant1", 64'(grants[1]), 64'd1);
            check("rr_grant2", 64'(grants[2]), 64'd0);
        end
        check("rr_ngaps", 64'(gaps.size()), 64'd2);
        if (gaps.size() == 2) begin
            check("rr_gap0", 64'(gaps[0]), 64'd13);
            check("rr_gap1", 64'(gaps[1]), 64'd13);
        end
        check("rr_done", 64'({ndone[1], ndone[0]}), {32'd1, 32'd2});

        // Watchdog (limit 8): source 1 streams forever, source 0 follows.
        do_reset(1'b1);
        len[1] = 1000; base[1] = 8'h40; nfr[1] = 1;
        len[0] = 3; base[0] = 8'h80; nfr[0] = 1; start[0] = 3;
        run_frames("wd", 400);
        check("wd_bytes1", 64'(nbytes[1]), 64'd8);
        check("wd_abort1", 64'(nabort[1]), 64'd1);
        check("wd_done1", 64'(ndone[1]), 64'd0);
        check("wd_done0", 64'(ndone[0]), 64'd1);
        check("wd_ncap", 64'(cap.size()), 64'd11);
        if (cap.size() == 11) begin
            check("wd_last_byte", 64'(cap[7]), 64'h47);
            check("wd_next_src_byte", 64'(cap[8]), 64'h80);
        end
        check("wd_order", 64'({grants.size(), (grants.size() > 0) ? grants[0] : 9}), {32'd2, 32'd1});
        check("wd_gap", (gaps.size() > 0) ? 64'(gaps[0]) : 64'hFFFF, 64'd13);

        // Request from source 1 arrives mid-GAP.
        do_reset(1'b0);
        len[0] = 4; base[0] = 8'h50; nfr[0] = 1;
        len[1] = 2; base[1] = 8'h60; nfr[1] = 1; start[1] = 10;
        run_frames("gapreq", 400);
        check("gapreq_en_in_gap", 64'(en_in_gap), 64'd0);
        check("gapreq_order", 64'({grants.size(), (grants.size() > 1) ? grants[1] : 9}), {32'd2, 32'd1});
        check("gapreq_gap", (gaps.size() > 0) ? 64'(gaps[0]) : 64'hFFFF, 64'd13);

        // Reset asserted mid-frame after 5 bytes.
        do_reset(1'b0);
        len[0] = 20; base[0] = 1; nfr[0] = 1;
        drive_src();
        for (int n = 0; n < 50 && nbytes[0] < 5; n++) cyc();
        check("midrst_bytes", 64'(nbytes[0]), 64'd5);
        check("midrst_active", 64'({txen_a, busy_a}), 64'b11);
        #3 rst = 1'b0;
        #1;
        check("midrst_outs", {txen_a, txd_a, en_a, busy_a, done_a, abort_a}, 64'd0);
        check("midrst_no_pulse", 64'(ndone[0] + nabort[0]), 64'd0);
        do_reset(1'b0);
        len[0] = 4; base[0] = 8'h30; nfr[0] = 1;
        run_frames("postrst", 200);
        check("postrst_grant", 64'({grants.size(), (grants.size() > 0) ? grants[0] : 9}), {32'd1, 32'd0});
        check("postrst_last", (cap.size() == 4) ? 64'(cap[3]) : 64'hFFFF, 64'h33);
        check("postrst_done", 64'(ndone[0]), 64'd1);

        // End of frame coincides with the byte limit (8): done wins.
        do_reset(1'b1);
        len[0] = 8; base[0] = 8'h10; nfr[0] = 1;
        run_frames("coin", 200);
        check("coin_done", 64'(ndone[0]), 64'd1);
        check("coin_abort", 64'(nabort[0]), 64'd0);
        check("coin_bytes", 64'(nbytes[0]), 64'd8);
        check("coin_last", (cap.size() == 8) ? 64'(cap[7]) : 64'hFFFF, 64'h17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
